// File: rtl/spi_master_pkg.sv
// Shared encodings and frame layout for the SPI command initiator.
package spi_master_pkg;

    localparam int unsigned FRAME_BITS = 10;
    localparam int unsigned RESP_BITS  = 8;
    localparam int unsigned CMD_BITS   = 2;
    localparam int unsigned CNT_BITS   = 4;
    localparam int unsigned STATE_BITS = 3;

    localparam logic [CMD_BITS-1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [CMD_BITS-1:0] CMD_WR_DATA = 2'b01;
    localparam logic [CMD_BITS-1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [CMD_BITS-1:0] CMD_RD_DATA = 2'b11;

    localparam logic [STATE_BITS-1:0] ST_IDLE    = 3'd0;
    localparam logic [STATE_BITS-1:0] ST_SELECT  = 3'd1;
    localparam logic [STATE_BITS-1:0] ST_SHIFT   = 3'd2;
    localparam logic [STATE_BITS-1:0] ST_WAIT    = 3'd3;
    localparam logic [STATE_BITS-1:0] ST_CAPTURE = 3'd4;
    localparam logic [STATE_BITS-1:0] ST_GAP     = 3'd5;

    typedef struct packed {
        logic [CMD_BITS-1:0]  cmd;
        logic [RESP_BITS-1:0] data;
    } frame_t;

endpackage

// File: rtl/spi_master.sv
// SPI command initiator: serialises 10-bit command frames under SS_n and
// captures the 8-bit reply for read-data commands.
module spi_master
    import spi_master_pkg::*;
#(
    parameter int unsigned READ_GAP = 2,
    parameter int unsigned IDLE_GAP = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [CMD_BITS-1:0]  req_cmd,
    input  logic [RESP_BITS-1:0] req_data,
    output logic                 rsp_valid,
    output logic [RESP_BITS-1:0] rsp_data,
    output logic                 busy,
    output logic                 SS_n,
    output logic                 MOSI,
    input  logic                 MISO
);

    logic [STATE_BITS-1:0] state_q, state_d;
    frame_t                frame_q, frame_d;
    logic [CNT_BITS-1:0]   bit_q, bit_d;
    logic [CNT_BITS-1:0]   gap_q, gap_d;
    logic [RESP_BITS-1:0]  rx_q, rx_d;

    logic                  req_ready_d, busy_d, ss_n_d, mosi_d, rsp_valid_d;
    logic [RESP_BITS-1:0]  rsp_data_d;

    // Next-state logic; outputs are decoded from the next state so they register cleanly.
    always_comb begin
        state_d     = state_q;
        frame_d     = frame_q;
        bit_d       = bit_q;
        gap_d       = gap_q;
        rx_d        = rx_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    frame_d.cmd  = req_cmd;
                    frame_d.data = req_data;
                    state_d      = ST_SELECT;
                end
            end
            ST_SELECT: begin
                bit_d   = CNT_BITS'(FRAME_BITS - 1);
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (bit_q == '0) begin
                    if (frame_q.cmd == CMD_RD_DATA) begin
                        gap_d   = CNT_BITS'(READ_GAP - 1);
                        state_d = ST_WAIT;
                    end else begin
                        gap_d   = CNT_BITS'(IDLE_GAP - 1);
                        state_d = ST_GAP;
                    end
                end else begin
                    bit_d = bit_q - CNT_BITS'(1);
                end
            end
            ST_WAIT: begin
                if (gap_q == '0) begin
                    bit_d   = CNT_BITS'(RESP_BITS - 1);
                    state_d = ST_CAPTURE;
                end else begin
                    gap_d = gap_q - CNT_BITS'(1);
                end
            end
            ST_CAPTURE: begin
                rx_d = {rx_q[RESP_BITS-2:0], MISO};
                if (bit_q == '0) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = rx_d;
                    gap_d       = CNT_BITS'(IDLE_GAP - 1);
                    state_d     = ST_GAP;
                end else begin
                    bit_d = bit_q - CNT_BITS'(1);
                end
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - CNT_BITS'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        ss_n_d = !((state_d == ST_SELECT) || (state_d == ST_SHIFT) ||
                   (state_d == ST_WAIT)   || (state_d == ST_CAPTURE));
        mosi_d = 1'b0;
        if (state_d == ST_SELECT) begin
            mosi_d = frame_d[FRAME_BITS-1];
        end else if (state_d == ST_SHIFT) begin
            mosi_d = frame_d[bit_d];
        end
        req_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            frame_q   <= '0;
            bit_q     <= '0;
            gap_q     <= '0;
            rx_q      <= '0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            SS_n      <= 1'b1;
            MOSI      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            bit_q     <= bit_d;
            gap_q     <= gap_d;
            rx_q      <= rx_d;
            req_ready <= req_ready_d;
            busy      <= busy_d;
            SS_n      <= ss_n_d;
            MOSI      <= mosi_d;
            rsp_valid <= rsp_valid_d;
            rsp_data  <= rsp_data_d;
        end
    end

endmodule

// File: doc/spi_master.md
# spi_master

Single-clock SPI command initiator that drives the 10-bit command frames consumed by the team's SPI slave + single-port RAM block (SPI_Wrapper). It accepts one command per valid/ready handshake, serialises it on MOSI under SS_n, and for read-data commands captures the 8-bit reply from MISO and returns it on a one-cycle response strobe. It sits between a host-side controller or testbench sequencer and the slave's serial pins, clocked from the same clk.

## Interface
- READ_GAP, 2: SS_n-low cycles with MOSI=0 between the last command bit and the first MISO sample (covers slave + RAM read latency); legal range 1..15.
- IDLE_GAP, 1: SS_n-high cycles after every frame before req_ready reasserts; legal range 1..15.

- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  command request.
- req_ready  out  1  high only in IDLE; transfer occurs on req_valid && req_ready.
- req_cmd  in  2  00 write address, 01 write data, 10 read address, 11 read data.
- req_data  in  8  address, write data, or don't-care (cmd 11, transmitted as given).
- rsp_valid  out  1  one-cycle pulse: rsp_data holds read result.
- rsp_data  out  8  captured read byte; holds until next capture.
- busy  out  1  high in every state except IDLE.
- SS_n  out  1  slave select, active low.
- MOSI  out  1  serial data to slave.
- MISO  in  1  serial data from slave.

## Operation
- Reset values: SS_n=1, MOSI=0, req_ready=1, busy=0, rsp_valid=0, rsp_data=8'h00, state IDLE.
- Frame word F[9:0] = {req_cmd, req_data}, latched at acceptance.
- States: IDLE → SELECT → SHIFT → (cmd 11: WAIT → CAPTURE) → GAP → IDLE.
- SELECT, 1 cycle: SS_n=0, MOSI=F[9] (slave's read/write select bit).
- SHIFT, 10 cycles: MOSI=F[9] down to F[0], MSB first; 4-bit down-counter.
- Cmd 00/01/10: after SHIFT go to GAP.
- WAIT, READ_GAP cycles: SS_n=0, MOSI=0.
- CAPTURE, 8 cycles: sample MISO each rising edge into shift register, MSB first.
- GAP, IDLE_GAP cycles: SS_n=1, MOSI=0. rsp_data loaded and rsp_valid pulsed on the GAP entry cycle for cmd 11 only.
- No command-order checking; host owns the 00/01 and 10/11 sequencing.
- rst in any state: next cycle equals reset values; frame abandoned, no rsp_valid.
- req_valid while busy: ignored, not queued; request inputs may change freely.

## Timing
- Acceptance edge = cycle 0. SS_n low and MOSI=F[9] from cycle 1 (SELECT); SHIFT bits on cycles 2..11.
- Write/addr frames: SS_n low exactly 11 cycles; SS_n=1 at cycle 12; req_ready=1 at cycle 12+IDLE_GAP.
- Read-data frame: WAIT cycles 12..11+READ_GAP; MISO sampled at the ends of cycles 12+READ_GAP..19+READ_GAP; SS_n=1 and rsp_valid=1 at cycle 20+READ_GAP.
- All outputs registered; no combinational path from any input to any output.
- Back-to-back requests with req_valid held high: minimum SS_n-high spacing is IDLE_GAP+1 cycles (GAP cycles plus the IDLE acceptance cycle).

## Structure
- Package spi_master_pkg: command encodings (CMD_WR_ADDR, CMD_WR_DATA, CMD_RD_ADDR, CMD_RD_DATA), state enum, FRAME_BITS=10, RESP_BITS=8.
- Single module, no sub-module: FSM, bit counter, gap counter, TX shift register and RX shift register inline.

## Test plan
- Write address 0x3C → MOSI over cycles 1..11 = 0,0,0,0,0,1,1,1,1,0,0; SS_n low for exactly 11 cycles; no rsp_valid.
- Read data, READ_GAP=2, MISO model returns 0xA5 → SS_n low cycles 1..21; rsp_valid at cycle 22 with rsp_data=0xA5.
- req_valid held high for three cmd-01 requests → each frame preceded by IDLE_GAP+1 SS_n-high cycles; req_ready low throughout busy.
- rst asserted during SHIFT bit 5 of a cmd-11 frame → next cycle SS_n=1, busy=0, rsp_valid never pulses, rsp_data=0x00.
- End-to-end with SPI_Wrapper: wr addr 0x10, wr data 0x5A, rd addr 0x10, rd data → rsp_data=0x5A.
- Read with MISO stuck at 1 then 0 → rsp_data=0xFF then 0x00; rsp_data holds between reads.
